// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 ALU datapath.
//   alu_op_e : ALU opcode encoding {alt, funct3}
//   REQ_ID_W : width of the requester tag carried with each operation
package msrv32_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    localparam int REQ_ID_W = 1;

endpackage

// File: rtl/msrv32_alu.sv
// Combinational RV32 integer ALU.
//   op_1_in, op_2_in : 32-bit operands
//   opcode_in        : {alt, funct3}; alt selects SUB / SRA
//   result_out       : 32-bit result, wrap-around arithmetic
module msrv32_alu (
    input  logic [31:0] op_1_in,
    input  logic [31:0] op_2_in,
    input  logic [3:0]  opcode_in,
    output logic [31:0] result_out
);

    logic [4:0] shamt;

    assign shamt = op_2_in[4:0];

    // Decode on funct3; alt only matters for the add/sub and shift-right pairs,
    // so every 4-bit code maps to some defined result.
    always_comb begin
        result_out = 32'd0;
        case (opcode_in[2:0])
            3'b000: result_out = opcode_in[3] ? (op_1_in - op_2_in) : (op_1_in + op_2_in);
            3'b001: result_out = op_1_in << shamt;
            3'b010: result_out = {31'd0, $signed(op_1_in) < $signed(op_2_in)};
            3'b011: result_out = {31'd0, op_1_in < op_2_in};
            3'b100: result_out = op_1_in ^ op_2_in;
            3'b101: result_out = opcode_in[3] ? 32'($signed(op_1_in) >>> shamt) : (op_1_in >> shamt);
            3'b110: result_out = op_1_in | op_2_in;
            3'b111: result_out = op_1_in & op_2_in;
            default: result_out = 32'd0;
        endcase
    end

endmodule

// File: rtl/msrv32_rr_arb2.sv
// Two-way combinational arbiter, round-robin or fixed priority.
//   valid_i      : request lines of requesters 1 and 0
//   last_grant_i : requester granted at the most recent accept
//   fixed_prio_i : 1 = requester 0 always wins a conflict
//   grant_o      : one-hot grant, or zero when nobody requests
module msrv32_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       fixed_prio_i,
    output logic [1:0] grant_o
);

    // On a conflict requester 0 wins under fixed priority, or when requester 1
    // was served last.
    assign grant_o[0] = valid_i[0] & (~valid_i[1] | fixed_prio_i | last_grant_i);
    assign grant_o[1] = valid_i[1] & ~grant_o[0];

endmodule

// File: rtl/msrv32_alu_arbiter.sv
// Shares one msrv32_alu between two valid/ready requesters through an
// issue register and a response register.
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in : clock, async active-low reset
//   reqN_valid_in, reqN_op_1_in, reqN_op_2_in, reqN_opcode_in, reqN_ready_out : requester N
//   rsp_valid_out, rsp_id_out, rsp_result_out, rsp_ready_in : tagged response channel
//   busy_out : an operation is held in either stage
module msrv32_alu_arbiter
    import msrv32_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_n_in,
    input  logic                req0_valid_in,
    input  logic [31:0]         req0_op_1_in,
    input  logic [31:0]         req0_op_2_in,
    input  logic [3:0]          req0_opcode_in,
    output logic                req0_ready_out,
    input  logic                req1_valid_in,
    input  logic [31:0]         req1_op_1_in,
    input  logic [31:0]         req1_op_2_in,
    input  logic [3:0]          req1_opcode_in,
    output logic                req1_ready_out,
    output logic                rsp_valid_out,
    output logic [REQ_ID_W-1:0] rsp_id_out,
    output logic [31:0]         rsp_result_out,
    input  logic                rsp_ready_in,
    output logic                busy_out
);

    logic                iss_vld_q, iss_vld_d;
    logic [31:0]         iss_op1_q, iss_op1_d;
    logic [31:0]         iss_op2_q, iss_op2_d;
    logic [3:0]          iss_opc_q, iss_opc_d;
    logic [REQ_ID_W-1:0] iss_id_q,  iss_id_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [REQ_ID_W-1:0] rsp_id_q,  rsp_id_d;
    logic [31:0]         rsp_res_q, rsp_res_d;
    logic                last_grant_q, last_grant_d;

    logic [1:0]  grant;
    logic        rsp_load, iss_free;
    logic        acc0, acc1, acc;
    logic [31:0] alu_res;

    msrv32_rr_arb2 u_arb (
        .valid_i      ({req1_valid_in, req0_valid_in}),
        .last_grant_i (last_grant_q),
        .fixed_prio_i (FIXED_PRIO),
        .grant_o      (grant)
    );

    msrv32_alu u_alu (
        .op_1_in    (iss_op1_q),
        .op_2_in    (iss_op2_q),
        .opcode_in  (iss_opc_q),
        .result_out (alu_res)
    );

    assign rsp_load = iss_vld_q & (~rsp_vld_q | rsp_ready_in);
    assign iss_free = ~iss_vld_q | rsp_load;

    // Ready is held low while reset is asserted so nothing is accepted into
    // registers that are being cleared.
    assign req0_ready_out = ms_riscv32_mp_rst_n_in & iss_free & grant[0];
    assign req1_ready_out = ms_riscv32_mp_rst_n_in & iss_free & grant[1];

    assign acc0 = req0_valid_in & req0_ready_out;
    assign acc1 = req1_valid_in & req1_ready_out;
    assign acc  = acc0 | acc1;

    always_comb begin
        iss_vld_d    = iss_vld_q;
        iss_op1_d    = iss_op1_q;
        iss_op2_d    = iss_op2_q;
        iss_opc_d    = iss_opc_q;
        iss_id_d     = iss_id_q;
        rsp_vld_d    = rsp_vld_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        last_grant_d = last_grant_q;

        // Issue stage: a new accept wins over the stage emptying.
        if (acc) begin
            iss_vld_d    = 1'b1;
            iss_op1_d    = acc1 ? req1_op_1_in   : req0_op_1_in;
            iss_op2_d    = acc1 ? req1_op_2_in   : req0_op_2_in;
            iss_opc_d    = acc1 ? req1_opcode_in : req0_opcode_in;
            iss_id_d     = REQ_ID_W'(acc1);
            last_grant_d = acc1;
        end else if (rsp_load) begin
            iss_vld_d = 1'b0;
        end

        // Response stage
        if (rsp_load) begin
            rsp_vld_d = 1'b1;
            rsp_id_d  = iss_id_q;
            rsp_res_d = alu_res;
        end else if (rsp_ready_in) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            iss_vld_q    <= 1'b0;
            iss_op1_q    <= 32'd0;
            iss_op2_q    <= 32'd0;
            iss_opc_q    <= 4'd0;
            iss_id_q     <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_res_q    <= 32'd0;
            last_grant_q <= RESET_LAST;
        end else begin
            iss_vld_q    <= iss_vld_d;
            iss_op1_q    <= iss_op1_d;
            iss_op2_q    <= iss_op2_d;
            iss_opc_q    <= iss_opc_d;
            iss_id_q     <= iss_id_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid_out  = rsp_vld_q;
    assign rsp_id_out     = rsp_id_q;
    assign rsp_result_out = rsp_res_q;
    assign busy_out       = iss_vld_q | rsp_vld_q;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench: two arbiter instances (index 0 round-robin, index 1 fixed priority)
// with a queue-based scoreboard and an operation-level reference model.
module tb_msrv32_alu_arbiter;
    import msrv32_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v0, v1, rdy_in;
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic [3:0]  o0 [2];
    logic [3:0]  o1 [2];
    logic [1:0]  r0, r1, rv, rid, bsy;
    logic [31:0] rres [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        msrv32_alu_arbiter #(.FIXED_PRIO(g == 1), .RESET_LAST(1'b1)) dut (
            .ms_riscv32_mp_clk_in   (clk),
            .ms_riscv32_mp_rst_n_in (rst_n),
            .req0_valid_in          (v0[g]),
            .req0_op_1_in           (a0[g]),
            .req0_op_2_in           (b0[g]),
            .req0_opcode_in         (o0[g]),
            .req0_ready_out         (r0[g]),
            .req1_valid_in          (v1[g]),
            .req1_op_1_in           (a1[g]),
            .req1_op_2_in           (b1[g]),
            .req1_opcode_in         (o1[g]),
            .req1_ready_out         (r1[g]),
            .rsp_valid_out          (rv[g]),
            .rsp_id_out             (rid[g:g]),
            .rsp_result_out         (rres[g]),
            .rsp_ready_in           (rdy_in[g]),
            .busy_out               (bsy[g])
        );
    end

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic        mlast [2];
    logic        hold  [2];
    logic        hid   [2];
    logic [31:0] hres  [2];
    logic [3:0]  op_tab [10];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference ALU straight from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_cmp(input int k);
        exp_t e;
        int   sz;
        sz = (k == 0) ? q0.size() : q1.size();
        chk1("rsp_expected", sz != 0, 1'b1);
        if (sz != 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk1("rsp_id", rid[k], e.id);
            chk32("rsp_result", rres[k], e.res);
        end
    endtask

    task automatic mon_inst(input int k);
        logic eg;
        if (hold[k]) begin
            chk1("rsp_hold_id", rid[k], hid[k]);
            chk32("rsp_hold_res", rres[k], hres[k]);
        end
        hold[k] = rv[k] & ~rdy_in[k];
        hid[k]  = rid[k];
        hres[k] = rres[k];
        if (rv[k] & rdy_in[k]) pop_cmp(k);
        if (r0[k] | r1[k]) begin
            if (v0[k] & v1[k]) eg = (k == 1) ? 1'b0 : ~mlast[k];
            else               eg = v1[k];
            chk32("grant", 32'({r1[k], r0[k]}), eg ? 32'd2 : 32'd1);
        end
        if (v0[k] & r0[k]) begin
            push(k, '{id: 1'b0, res: ref_alu(o0[k], a0[k], b0[k])});
            mlast[k] = 1'b0;
        end
        if (v1[k] & r1[k]) begin
            push(k, '{id: 1'b1, res: ref_alu(o1[k], a1[k], b1[k])});
            mlast[k] = 1'b1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                mon_inst(0);
                mon_inst(1);
            end
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            mlast[k] = 1'b1;
            hold[k]  = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int r, input logic vl, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin v0[k] = vl; o0[k] = op; a0[k] = a; b0[k] = b; end
        else        begin v1[k] = vl; o1[k] = op; a1[k] = a; b1[k] = b; end
    endtask

    task automatic issue(input int k, input int r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        logic done = 1'b0;
        set_req(k, r, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if ((r == 0) ? r0[k] : r1[k]) done = 1'b1;
            cyc();
        end
        chk1("issue_accepted", done, 1'b1);
        if (r == 0) v0[k] = 1'b0;
        else        v1[k] = 1'b0;
    endtask

    initial begin
        op_tab = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                   ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
        for (int k = 0; k < 2; k++) begin
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0; o0[k] = '0; o1[k] = '0;
        end
        model_reset();
        rst_n  = 1'b0;
        v0     = 2'b11;
        v1     = 2'b11;
        rdy_in = 2'b11;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state, with requests pending.
        #12;
        for (int k = 0; k < 2; k++) begin
            chk1("reset_rsp_valid", rv[k], 1'b0);
            chk1("reset_rsp_id", rid[k], 1'b0);
            chk32("reset_rsp_result", rres[k], 32'd0);
            chk1("reset_busy", bsy[k], 1'b0);
            chk1("reset_ready0", r0[k], 1'b0);
            chk1("reset_ready1", r1[k], 1'b0);
        end
        v0 = 2'b00;
        v1 = 2'b00;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();

        // Single ADD with two-cycle latency.
        set_req(0, 0, 1'b1, ALU_ADD, 32'd5, 32'd3);
        #1 chk1("single_ready", r0[0], 1'b1);
        cyc();
        v0[0] = 1'b0;
        chk1("single_lat1_valid", rv[0], 1'b0);
        chk1("single_lat1_busy", bsy[0], 1'b1);
        cyc();
        chk1("single_lat2_valid", rv[0], 1'b1);
        chk1("single_lat2_id", rid[0], 1'b0);
        chk32("single_lat2_result", rres[0], 32'd8);
        repeat (3) cyc();

        // Round-robin with both requesters continuously valid.
        set_req(0, 0, 1'b1, ALU_XOR, 32'hF0F0_0000, 32'h0F0F_0000);
        set_req(0, 1, 1'b1, ALU_SUB, 32'd7, 32'd9);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("rr_one_ready", r0[0] ^ r1[0], 1'b1);
            chk1("rr_order", r1[0], (i % 2) == 0);
            if (i >= 2) chk1("rr_full_rate", rv[0], 1'b1);
            cyc();
        end
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        repeat (4) cyc();

        // Backpressure: two SLLs fill the pipe, the third must wait.
        rdy_in[0] = 1'b0;
        issue(0, 1, ALU_SLL, 32'd1, 32'd1);
        issue(0, 1, ALU_SLL, 32'd1, 32'd2);
        set_req(0, 1, 1'b1, ALU_SLL, 32'd1, 32'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_ready_low", r1[0], 1'b0);
            chk1("bp_busy", bsy[0], 1'b1);
            cyc();
        end
        rdy_in[0] = 1'b1;
        begin
            logic done = 1'b0;
            for (int i = 0; i < 10 && !done; i++) begin
                #1;
                if (r1[0]) done = 1'b1;
                cyc();
            end
            chk1("bp_third_accepted", done, 1'b1);
        end
        v1[0] = 1'b0;
        repeat (4) cyc();

        // Fixed priority: requester 1 starves while requester 0 is valid.
        set_req(1, 1, 1'b1, ALU_AND, 32'hDEAD_BEEF, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            set_req(1, 0, 1'b1, op_tab[$urandom_range(0, 9)], $urandom, $urandom);
            #1 chk1("fp_req1_blocked", r1[1], 1'b0);
            cyc();
        end
        v0[1] = 1'b0;
        #1 chk1("fp_req1_granted", r1[1], 1'b1);
        cyc();
        v1[1] = 1'b0;
        repeat (4) cyc();

        // Signed shift and compares.
        issue(0, 0, ALU_SRA, 32'h8000_0000, 32'd4);
        issue(0, 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(0, 1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        repeat (4) cyc();

        // Randomized traffic on both instances with random backpressure.
        begin
            logic acc0 [2];
            logic acc1 [2];
            for (int k = 0; k < 2; k++) begin acc0[k] = 1'b0; acc1[k] = 1'b0; end
            for (int c = 0; c < 400; c++) begin
                for (int k = 0; k < 2; k++) begin
                    rdy_in[k] = ($urandom_range(0, 3) != 0);
                    if (!v0[k] || acc0[k])
                        set_req(k, 0, 1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 9)],
                                $urandom, $urandom);
                    if (!v1[k] || acc1[k])
                        set_req(k, 1, 1'($urandom_range(0, 1)), op_tab[$urandom_range(0, 9)],
                                $urandom, $urandom);
                end
                #1;
                for (int k = 0; k < 2; k++) begin
                    acc0[k] = v0[k] & r0[k];
                    acc1[k] = v1[k] & r1[k];
                end
                cyc();
            end
        end
        v0 = 2'b00;
        v1 = 2'b00;
        rdy_in = 2'b11;
        repeat (6) cyc();
        chk32("drain_q0", 32'(q0.size()), 32'd0);
        chk32("drain_q1", 32'(q1.size()), 32'd0);
        chk1("drain_busy0", bsy[0], 1'b0);
        chk1("drain_busy1", bsy[1], 1'b0);

        // Asynchronous reset with two operations in flight.
        rdy_in[0] = 1'b0;
        issue(0, 0, ALU_ADD, 32'd1, 32'd2);
        issue(0, 1, ALU_ADD, 32'd3, 32'd4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("arst_rsp_valid", rv[0], 1'b0);
        chk1("arst_busy", bsy[0], 1'b0);
        model_reset();
        rdy_in = 2'b11;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("arst_no_stale", rv[0], 1'b0);
        end
        set_req(0, 0, 1'b1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        set_req(0, 1, 1'b1, ALU_SRL, 32'h8000_0000, 32'd31);
        #1 chk32("arst_first_grant", 32'({r1[0], r0[0]}), 32'd1);
        cyc();
        v0[0] = 1'b0;
        begin
            logic done = 1'b0;
            for (int i = 0; i < 10 && !done; i++) begin
                #1;
                if (r1[0]) done = 1'b1;
                cyc();
            end
            chk1("arst_second_accepted", done, 1'b1);
        end
        v1[0] = 1'b0;
        repeat (5) cyc();
        chk32("final_q0", 32'(q0.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
